// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath width, ARM register count and
// named indices for the banked special-purpose registers.
package cpu_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int ARM_NUM_REGS = 16;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

endpackage : cpu_pkg

// File: rtl/rf_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set by decode
// reservations and cleared by write-back or a pipeline flush.
module rf_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_ok_i,
  input  logic [SEL_W-1:0]    wr_sel_i,
  input  logic                rsv_ok_i,
  input  logic [SEL_W-1:0]    rsv_sel_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_vec_o,
  output logic [NUM_REGS-1:0] busy_nxt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Reservation is applied after the write so a same-register pair ends busy;
  // a flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok_i && (wr_sel_i == SEL_W'(i)))
          busy_d[i] = 1'b0;
        if (rsv_ok_i && (rsv_sel_i == SEL_W'(i)))
          busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;
  assign busy_nxt_o = busy_d;

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// Multi-port architectural register file with registered read ports,
// write-to-read bypass and an integrated write-pending scoreboard.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = CPU_DATA_W,
  parameter  int NUM_REGS = ARM_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 0,
  localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [SEL_W-1:0]         rsv_sel,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy_vec
);

  // A select is usable only if it names a real, writable register.
  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    logic [31:0] idx;
    idx = 32'(s);
    return (idx < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (idx == 32'd0));
  endfunction

  logic                     wr_ok, rsv_ok;
  logic [NUM_REGS-1:0]      busy_nxt;
  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

  assign wr_ok  = wr_en  && sel_ok(wr_sel);
  assign rsv_ok = rsv_en && sel_ok(rsv_sel);

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_ok_i    (wr_ok),
    .wr_sel_i   (wr_sel),
    .rsv_ok_i   (rsv_ok),
    .rsv_sel_i  (rsv_sel),
    .flush_i    (flush),
    .busy_vec_o (busy_vec),
    .busy_nxt_o (busy_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel == SEL_W'(i))
          regs_q[i] <= wr_data;
    end
  end

  // Busy is taken from the post-edge scoreboard; a same-edge write bypasses both.
  always_comb begin
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              busy;
    sel       = '0;
    data      = '0;
    busy      = 1'b0;
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_en[k]) begin
        sel  = rd_sel[k*SEL_W +: SEL_W];
        data = '0;
        busy = 1'b0;
        if (sel_ok(sel)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
              data = regs_q[i];
              busy = busy_nxt[i];
            end
          end
          if (wr_ok && (wr_sel == sel)) begin
            data = wr_data;
            busy = 1'b0;
          end
        end
        rd_data_d[k*DATA_W +: DATA_W] = data;
        rd_busy_d[k]                  = busy;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a default ARM-sized instance driven from a
// vector table, and a zero-register/non-power-of-two instance for corner cases.
module tb_reg_file_sb;

  logic clk;
  logic rstA, rstB;

  logic [1:0]  aRdEn;
  logic [7:0]  aRdSel;
  logic [63:0] aRdData;
  logic [1:0]  aRdBusy;
  logic        aWrEn;
  logic [3:0]  aWrSel;
  logic [31:0] aWrData;
  logic        aRsvEn;
  logic [3:0]  aRsvSel;
  logic        aFlush;
  logic [15:0] aBusyVec;

  logic [2:0]  bRdEn;
  logic [11:0] bRdSel;
  logic [95:0] bRdData;
  logic [2:0]  bRdBusy;
  logic        bWrEn;
  logic [3:0]  bWrSel;
  logic [31:0] bWrData;
  logic        bRsvEn;
  logic [3:0]  bRsvSel;
  logic        bFlush;
  logic [11:0] bBusyVec;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        wrEn;
    logic [3:0]  wrSel;
    logic [31:0] wrData;
    logic        rsvEn;
    logic [3:0]  rsvSel;
    logic        flush;
    logic [1:0]  rdEn;
    logic [3:0]  sel0;
    logic [3:0]  sel1;
    logic [31:0] expD0;
    logic        expB0;
    logic [31:0] expD1;
    logic        expB1;
    logic [15:0] expBv;
  } vec_t;

  vec_t vecs [14];

  reg_file_sb dutA (
    .clk      (clk),
    .reset    (rstA),
    .rd_en    (aRdEn),
    .rd_sel   (aRdSel),
    .rd_data  (aRdData),
    .rd_busy  (aRdBusy),
    .wr_en    (aWrEn),
    .wr_sel   (aWrSel),
    .wr_data  (aWrData),
    .rsv_en   (aRsvEn),
    .rsv_sel  (aRsvSel),
    .flush    (aFlush),
    .busy_vec (aBusyVec)
  );

  reg_file_sb #(
    .DATA_W   (32),
    .NUM_REGS (12),
    .NUM_RD   (3),
    .ZERO_REG (1)
  ) dutB (
    .clk      (clk),
    .reset    (rstB),
    .rd_en    (bRdEn),
    .rd_sel   (bRdSel),
    .rd_data  (bRdData),
    .rd_busy  (bRdBusy),
    .wr_en    (bWrEn),
    .wr_sel   (bWrSel),
    .wr_data  (bWrData),
    .rsv_en   (bRsvEn),
    .rsv_sel  (bRsvSel),
    .flush    (bFlush),
    .busy_vec (bBusyVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    aRdEn = '0; aRdSel = '0; aWrEn = 1'b0; aWrSel = '0; aWrData = '0;
    aRsvEn = 1'b0; aRsvSel = '0; aFlush = 1'b0;
    bRdEn = '0; bRdSel = '0; bWrEn = 1'b0; bWrSel = '0; bWrData = '0;
    bRsvEn = 1'b0; bRsvSel = '0; bFlush = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    aWrEn = v.wrEn; aWrSel = v.wrSel; aWrData = v.wrData;
    aRsvEn = v.rsvEn; aRsvSel = v.rsvSel; aFlush = v.flush;
    aRdEn = v.rdEn; aRdSel = {v.sel1, v.sel0};
    @(posedge clk);
    #1;
  endtask

  task automatic stepB(input logic wrEn, input logic [3:0] wrSel, input logic [31:0] wrData,
                       input logic rsvEn, input logic [3:0] rsvSel, input logic [2:0] rdEn,
                       input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    bWrEn = wrEn; bWrSel = wrSel; bWrData = wrData;
    bRsvEn = rsvEn; bRsvSel = rsvSel; bFlush = 1'b0;
    bRdEn = rdEn; bRdSel = {s2, s1, s0};
    @(posedge clk);
    #1;
  endtask

  task automatic checkB(input string name, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [2:0] busy, input logic [11:0] bv);
    checkOutput({name, " d0"}, bRdData[31:0], d0);
    checkOutput({name, " d1"}, bRdData[63:32], d1);
    checkOutput({name, " d2"}, bRdData[95:64], d2);
    checkOutput({name, " busy"}, 32'(bRdBusy), 32'(busy));
    checkOutput({name, " busy_vec"}, 32'(bBusyVec), 32'(bBusyVec == bv ? bv : bv));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 2'b00, 4'd0,  4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 2'b01, 4'd3,  4'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 4'd5,  32'h1234,     1'b0, 4'd0, 1'b0, 2'b10, 4'd0,  4'd5,  32'hDEADBEEF, 1'b0, 32'h1234,     1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd7, 1'b0, 2'b01, 4'd7,  4'd0,  32'h0,        1'b1, 32'h1234,     1'b0, 16'h0080};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 2'b11, 4'd7,  4'd7,  32'h0,        1'b1, 32'h0,        1'b1, 16'h0080};
    vecs[5]  = '{1'b1, 4'd7,  32'h55,       1'b1, 4'd7, 1'b0, 2'b00, 4'd0,  4'd0,  32'h0,        1'b1, 32'h0,        1'b1, 16'h0080};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 2'b11, 4'd7,  4'd7,  32'h55,       1'b1, 32'h55,       1'b1, 16'h0080};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd1, 1'b0, 2'b00, 4'd0,  4'd0,  32'h55,       1'b1, 32'h55,       1'b1, 16'h0082};
    vecs[8]  = '{1'b1, 4'd1,  32'hA1,       1'b1, 4'd2, 1'b0, 2'b01, 4'd1,  4'd0,  32'hA1,       1'b0, 32'h55,       1'b1, 16'h0084};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd9, 1'b0, 2'b10, 4'd0,  4'd9,  32'hA1,       1'b0, 32'h0,        1'b1, 16'h0284};
    vecs[10] = '{1'b1, 4'd10, 32'hCAFE,     1'b1, 4'd4, 1'b1, 2'b01, 4'd4,  4'd0,  32'h0,        1'b0, 32'h0,        1'b1, 16'h0000};
    vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 2'b11, 4'd10, 4'd3,  32'hCAFE,     1'b0, 32'hDEADBEEF, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 2'b11, 4'd15, 4'd15, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 2'b11, 4'd5,  4'd5,  32'h1234,     1'b0, 32'h1234,     1'b0, 16'h0000};

    idleInputs();
    rstA = 1'b0;
    rstB = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstA = 1'b1;
    rstB = 1'b1;
    #1;
    checkOutput("A reset rd_data lo", aRdData[31:0], 32'h0);
    checkOutput("A reset rd_data hi", aRdData[63:32], 32'h0);
    checkOutput("A reset rd_busy", 32'(aRdBusy), 32'h0);
    checkOutput("A reset busy_vec", 32'(aBusyVec), 32'h0);

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 2'b11, 4'(i), 4'(15 - i),
            32'h0, 1'b0, 32'h0, 1'b0, 16'h0000};
      applyStimulus(v);
      checkOutput($sformatf("A clean r%0d p0", i), aRdData[31:0], 32'h0);
      checkOutput($sformatf("A clean r%0d p1", 15 - i), aRdData[63:32], 32'h0);
      checkOutput($sformatf("A clean busy %0d", i), 32'(aRdBusy), 32'h0);
      checkOutput($sformatf("A clean busy_vec %0d", i), 32'(aBusyVec), 32'h0);
    end

    for (int n = 0; n < 14; n++) begin
      applyStimulus(vecs[n]);
      checkOutput($sformatf("A vec%0d d0", n), aRdData[31:0], vecs[n].expD0);
      checkOutput($sformatf("A vec%0d b0", n), 32'(aRdBusy[0]), 32'(vecs[n].expB0));
      checkOutput($sformatf("A vec%0d d1", n), aRdData[63:32], vecs[n].expD1);
      checkOutput($sformatf("A vec%0d b1", n), 32'(aRdBusy[1]), 32'(vecs[n].expB1));
      checkOutput($sformatf("A vec%0d busy_vec", n), 32'(aBusyVec), 32'(vecs[n].expBv));
    end
    @(negedge clk);
    idleInputs();

    // Zero-register, 12-entry, 3-port instance.
    stepB(1'b1, 4'd11, 32'h11, 1'b0, 4'd0,  3'b000, 4'd0,  4'd0,  4'd0);
    stepB(1'b1, 4'd0,  32'hFF, 1'b0, 4'd0,  3'b111, 4'd0,  4'd0,  4'd0);
    checkB("B r0 write ignored", 32'h0, 32'h0, 32'h0, 3'b000, 12'h000);
    stepB(1'b1, 4'd13, 32'hAB, 1'b1, 4'd0,  3'b111, 4'd0,  4'd11, 4'd13);
    checkB("B sel13 write", 32'h0, 32'h11, 32'h0, 3'b000, 12'h000);
    stepB(1'b0, 4'd0,  32'h0,  1'b1, 4'd12, 3'b111, 4'd11, 4'd12, 4'd15);
    checkB("B rsv out of range", 32'h11, 32'h0, 32'h0, 3'b000, 12'h000);
    stepB(1'b0, 4'd0,  32'h0,  1'b1, 4'd11, 3'b111, 4'd11, 4'd11, 4'd11);
    checkB("B rsv r11 all ports", 32'h11, 32'h11, 32'h11, 3'b111, 12'h800);

    // Reset lands between edges during a write burst: outputs clear at once.
    stepB(1'b1, 4'd5, 32'h77, 1'b0, 4'd0, 3'b001, 4'd11, 4'd0, 4'd0);
    bWrSel = 4'd6;
    bWrData = 32'h66;
    #1;
    rstB = 1'b0;
    #1;
    checkB("B async reset", 32'h0, 32'h0, 32'h0, 3'b000, 12'h000);
    @(negedge clk);
    idleInputs();
    rstB = 1'b1;
    stepB(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 3'b111, 4'd5, 4'd6, 4'd11);
    checkB("B after reset", 32'h0, 32'h0, 32'h0, 3'b000, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-port register file with an integrated write-pending scoreboard. It serves as the architectural register storage for the ARM core.
- Decode reserves a destination register.
- Write-back writes the register and releases the reservation.
- Operand reads are synchronous, with write-to-read bypass and per-port busy flags, so issue logic can stall on RAW hazards.
- Generalises the earlier two-read-port bank in data width, depth, read-port count and optional hardwired-zero register.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of architectural registers (need not be a power of two)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never busy
SEL_W (localparam), $clog2(NUM_REGS), register selector width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_en  in  NUM_RD  per-port read strobe
rd_sel  in  NUM_RD*SEL_W  per-port register select; port k at bits [k*SEL_W +: SEL_W]
rd_data  out  NUM_RD*DATA_W  registered read data; port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  registered busy flag of the register read on port k
wr_en  in  1  write-back strobe
wr_sel  in  SEL_W  write-back register
wr_data  in  DATA_W  write-back data
rsv_en  in  1  reserve (mark pending) strobe from decode
rsv_sel  in  SEL_W  register to reserve
flush  in  1  clear all reservations (pipeline flush)
busy_vec  out  NUM_REGS  current scoreboard, bit i = register i pending

Behaviour:
- Reset (reset=0, async): all registers 0, busy_vec 0, rd_data 0, rd_busy 0. Reset applied mid-operation aborts any in-flight write; the next edge after release sees clean state.
- Write: on a rising edge with wr_en=1 and wr_sel<NUM_REGS, the register takes wr_data and its busy bit clears.
  - wr_sel>=NUM_REGS: no effect.
  - ZERO_REG=1 and wr_sel=0: no effect.
- Read: latency 1 cycle. When rd_en[k]=1 at edge T, rd_data/rd_busy for port k update after T. When rd_en[k]=0, port k holds its previous outputs.
  - Read data is the register value before edge T.
  - Bypass exception: if a write to the same register occurs at edge T, rd_data returns wr_data and rd_busy returns 0.
  - Out-of-range select: rd_data=0, rd_busy=0.
  - Register 0 with ZERO_REG=1: rd_data=0, rd_busy=0.
- Busy for reads: rd_busy[k] reflects the scoreboard after edge T's updates, i.e. includes a rsv at T.
- Reserve: rsv_en=1 sets busy[rsv_sel] at the edge. Same rules as write for out-of-range and zero-register selects.
- Simultaneous write and reserve to the same register: data written, busy ends 1 (the new reservation wins).
- Simultaneous write and reserve to different registers: both apply.
- flush=1: all busy bits clear at the edge. A rsv_en in the same cycle is ignored. A write in the same cycle still updates data.
- Multiple read ports selecting the same register: all ports return identical data.
- busy_vec is a direct register output, with no combinational path from inputs.
- No combinational path from any input to rd_data or rd_busy.

Decomposition:
- Shared package (cpu_pkg): DATA_W default, ARM register count constant (16), named indices for SP=13, LR=14, PC=15.
- One sub-module, rf_scoreboard: holds busy bits and implements the rsv/wr/flush priority; outputs busy_vec.
- Storage, bypass and read ports stay in reg_file_sb.

Test Plan:
1. Reset release, then read r0..r15 on both ports -> all rd_data=0, rd_busy=0, busy_vec=0.
2. Write r3=0xDEADBEEF; next cycle read port0 r3 -> rd_data=0xDEADBEEF, rd_busy=0.
3. Write r5=0x1234 and, in the same cycle, read port1 r5 -> port1 rd_data=0x1234 next cycle (bypass). The old value must not appear.
4. rsv r7; next cycle read r7 -> rd_busy=1 and busy_vec[7]=1. Then wr r7=0x55 with rsv r7 in the same cycle -> r7 reads 0x55, busy_vec[7] stays 1.
5. Reserve r1, r2, r9, then flush with rsv r4 in the same cycle -> busy_vec=0.
6. ZERO_REG=1, NUM_REGS=12, NUM_RD=3:
   - wr r0=0xFF and wr sel 13 -> r0 reads 0; no register changes.
   - Sel 13 reads 0 and not busy.
   - Assert reset mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
